// File: rtl/multiplier_ct_taint.sv
// multiplier_ct_taint
//   Constant-time shift-and-add unsigned multiplier with taint tracking.
//   Each operation runs IDLE -> LOAD -> CALC (NUM_BITS cycles) -> DONE -> IDLE,
//   whatever the operand values or taints.
//   Taint is propagated conservatively: each tainted addend bit smears upward
//   through all higher accumulator bits, because a carry could reach them.
//
// Parameters
//   NUM_BITS        operand width (>= 2)
//
// Ports
//   clk             sole clock, rising edge
//   rst_n           asynchronous active-low reset
//   start           operation request, sampled in IDLE only
//   multiplier      operand A        multiplier_t    per-bit taint of A
//   multiplicand    operand B        multiplicand_t  per-bit taint of B
//   start_t         taint of start
//   busy            high in LOAD and CALC
//   done            one-cycle pulse, product valid
//   product         A*B (2*NUM_BITS) product_t       per-bit taint of product
//   done_t          taint of done/busy timing
//   taint_kill      (only with MULT_TAINT_KILL_EN) clears all taint state
//
// Build option
//   MULT_TAINT_KILL_EN  adds the taint_kill input.
module multiplier_ct_taint #(
    parameter int NUM_BITS = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [NUM_BITS-1:0]   multiplier,
    input  logic [NUM_BITS-1:0]   multiplicand,
    input  logic                  start_t,
    input  logic [NUM_BITS-1:0]   multiplier_t,
    input  logic [NUM_BITS-1:0]   multiplicand_t,
`ifdef MULT_TAINT_KILL_EN
    input  logic                  taint_kill,
`endif
    output logic                  busy,
    output logic                  done,
    output logic [2*NUM_BITS-1:0] product,
    output logic [2*NUM_BITS-1:0] product_t,
    output logic                  done_t
);
    localparam int PW = 2 * NUM_BITS;
    localparam int CW = (NUM_BITS > 2) ? $clog2(NUM_BITS) : 1;

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_CALC, S_DONE} state_t;

    state_t              r_state;
    state_t              w_state_next;
    logic [NUM_BITS-1:0] r_a, r_b, r_a_t, r_b_t;
    logic                r_start_t;
    logic [PW-1:0]       r_acc, r_acc_t;
    logic [CW-1:0]       r_count;
    logic [PW-1:0]       r_product, r_product_t;
    logic                r_done, r_done_t;

    logic                w_kill;
    logic                w_last;
    logic [PW-1:0]       w_b_wide, w_bt_wide, w_window;
    logic [PW-1:0]       w_addend, w_addend_t, w_smear;
    logic [PW-1:0]       w_acc_next, w_acc_t_next;

`ifdef MULT_TAINT_KILL_EN
    assign w_kill = taint_kill;
`else
    assign w_kill = 1'b0;
`endif

    assign w_last    = (r_count == CW'(NUM_BITS - 1));
    assign w_b_wide  = {{NUM_BITS{1'b0}}, r_b};
    assign w_bt_wide = {{NUM_BITS{1'b0}}, r_b_t};
    // NUM_BITS-wide window of ones starting at the current iteration bit.
    assign w_window  = {{NUM_BITS{1'b0}}, {NUM_BITS{1'b1}}} << r_count;

    // Always compute the addend so every iteration has identical timing.
    assign w_addend   = r_a[r_count] ? (w_b_wide << r_count) : '0;
    assign w_addend_t = r_a_t[r_count] ? w_window :
                        (r_a[r_count] ? (w_bt_wide << r_count) : '0);
    // x | -x sets every bit from the lowest set bit of x upward (0 stays 0).
    assign w_smear      = w_addend_t | (~w_addend_t + PW'(1));
    assign w_acc_next   = r_acc + w_addend;
    assign w_acc_t_next = r_acc_t | w_smear;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (start) w_state_next = S_LOAD;
            S_LOAD:  w_state_next = S_CALC;
            S_CALC:  if (w_last) w_state_next = S_DONE;
            S_DONE:  w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a         <= '0;
            r_b         <= '0;
            r_a_t       <= '0;
            r_b_t       <= '0;
            r_start_t   <= 1'b0;
            r_acc       <= '0;
            r_acc_t     <= '0;
            r_count     <= '0;
            r_product   <= '0;
            r_product_t <= '0;
            r_done      <= 1'b0;
            r_done_t    <= 1'b0;
        end else begin
            // The result lands on DONE entry; the pulse is registered from the
            // DONE state so it follows one edge later with the result stable.
            r_done <= (r_state == S_DONE);
            case (r_state)
                S_LOAD: begin
                    r_a       <= multiplier;
                    r_b       <= multiplicand;
                    r_a_t     <= multiplier_t;
                    r_b_t     <= multiplicand_t;
                    r_start_t <= start_t;
                    r_acc     <= '0;
                    r_acc_t   <= '0;
                    r_count   <= '0;
                end
                S_CALC: begin
                    r_acc   <= w_acc_next;
                    r_acc_t <= w_acc_t_next;
                    r_count <= r_count + CW'(1);
                    if (w_last) begin
                        r_product   <= w_acc_next;
                        r_product_t <= r_start_t ? '1 : w_acc_t_next;
                        r_done_t    <= r_start_t;
                    end
                end
                default: ;
            endcase
            // Declassification overrides every taint update in the same cycle.
            if (w_kill) begin
                r_a_t       <= '0;
                r_b_t       <= '0;
                r_start_t   <= 1'b0;
                r_acc_t     <= '0;
                r_product_t <= '0;
                r_done_t    <= 1'b0;
            end
        end
    end

    assign busy      = (r_state == S_LOAD) || (r_state == S_CALC);
    assign done      = r_done;
    assign product   = r_product;
    assign product_t = r_product_t;
    assign done_t    = r_done_t;

endmodule

// File: tb/tb_multiplier_ct_taint.sv
module tb_multiplier_ct_taint;
    localparam int N = 8;

    logic        clk = 1'b0;
    logic        rst_n, start, start_t;
    logic [7:0]  mplier, mcand, mplier_t, mcand_t;
    logic        busy, done, done_t;
    logic [15:0] product, product_t;
`ifdef MULT_TAINT_KILL_EN
    logic        taint_kill;
`endif
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    multiplier_ct_taint #(.NUM_BITS(N)) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .multiplier(mplier), .multiplicand(mcand), .start_t(start_t),
        .multiplier_t(mplier_t), .multiplicand_t(mcand_t),
`ifdef MULT_TAINT_KILL_EN
        .taint_kill(taint_kill),
`endif
        .busy(busy), .done(done), .product(product),
        .product_t(product_t), .done_t(done_t)
    );

    // Reference taint: per iteration build the addend taint, then mark every
    // bit from its lowest set bit to the top as tainted.
    function automatic logic [15:0] model_t(input logic [7:0] a, b, at, bt, input logic st);
        logic [15:0] acc, add;
        acc = 16'h0;
        if (st) return 16'hFFFF;
        for (int i = 0; i < N; i++) begin
            if (at[i])      add = 16'h00FF << i;
            else if (a[i])  add = {8'h00, bt} << i;
            else            add = 16'h0;
            for (int j = 0; j < 16; j++) begin
                if (add[j]) begin
                    for (int k = j; k < 16; k++) acc[k] = 1'b1;
                    break;
                end
            end
        end
        return acc;
    endfunction

    // Starts one operation and counts edges after the sampling edge until
    // done is seen (bounded).
    task automatic run_op(input logic [7:0] a, b, at, bt, input logic st, output int lat);
        @(negedge clk);
        mplier = a; mcand = b; mplier_t = at; mcand_t = bt; start_t = st; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        lat = 0;
        while (done !== 1'b1 && lat < 30) begin
            @(posedge clk);
            #1 lat++;
        end
        $display("op A=%0d B=%0d At=%h Bt=%h st=%b -> P=%0d Pt=%h dt=%b lat=%0d",
                 a, b, at, bt, st, product, product_t, done_t, lat);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; start_t = 1'b0;
        mplier = 8'h0; mcand = 8'h0; mplier_t = 8'h0; mcand_t = 8'h0;
`ifdef MULT_TAINT_KILL_EN
        taint_kill = 1'b0;
`endif
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({busy, done, done_t, product, product_t} !== 35'h0) begin
            errors++;
            $display("FAIL reset_outputs: got busy=%b done=%b dt=%b P=%h Pt=%h, want all 0",
                     busy, done, done_t, product, product_t);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_arith();
        logic [7:0] ta [5] = '{8'd15, 8'd0, 8'd92, 8'd42, 8'd255};
        logic [7:0] tb [5] = '{8'd15, 8'd12, 8'd75, 8'd78, 8'd255};
        logic [15:0] tp [5] = '{16'd225, 16'd0, 16'd6900, 16'd3276, 16'd65025};
        int lat;
        logic [15:0] held;
        for (int i = 0; i < 5; i++) begin
            run_op(ta[i], tb[i], 8'h0, 8'h0, 1'b0, lat);
            checks++;
            if (lat != 10) begin errors++; $display("FAIL arith_latency: got %0d want 10", lat); end
            checks++;
            if (product !== tp[i]) begin errors++; $display("FAIL arith_product: got %0d want %0d", product, tp[i]); end
            checks++;
            if (product_t !== 16'h0 || done_t !== 1'b0 || busy !== 1'b0) begin
                errors++;
                $display("FAIL arith_taint: got Pt=%h dt=%b busy=%b want 0 0 0", product_t, done_t, busy);
            end
            held = product;
            @(posedge clk);
            #1;
            checks++;
            if (done !== 1'b0 || product !== held) begin
                errors++;
                $display("FAIL arith_pulse_hold: got done=%b P=%0d want 0 %0d", done, product, held);
            end
        end
    endtask

    task automatic test_taint();
        logic [7:0]  ta  [3] = '{8'd1, 8'd1, 8'd3};
        logic [7:0]  tb  [3] = '{8'd2, 8'd2, 8'd5};
        logic [7:0]  tat [3] = '{8'h00, 8'h04, 8'h00};
        logic [7:0]  tbt [3] = '{8'h80, 8'h00, 8'h00};
        logic        tst [3] = '{1'b0, 1'b0, 1'b1};
        logic [15:0] ept [3] = '{16'hFF80, 16'hFFFC, 16'hFFFF};
        int lat;
        for (int i = 0; i < 3; i++) begin
            run_op(ta[i], tb[i], tat[i], tbt[i], tst[i], lat);
            checks++;
            if (lat != 10 || product !== 16'(ta[i]) * 16'(tb[i])) begin
                errors++;
                $display("FAIL taint_product: got P=%0d lat=%0d want %0d lat 10", product, lat, 16'(ta[i]) * 16'(tb[i]));
            end
            checks++;
            if (product_t !== ept[i] || done_t !== tst[i]) begin
                errors++;
                $display("FAIL taint_value: got Pt=%h dt=%b want %h %b", product_t, done_t, ept[i], tst[i]);
            end
        end
    endtask

    task automatic test_random();
        logic [7:0] a, b, at, bt;
        logic st;
        int lat;
        for (int i = 0; i < 25; i++) begin
            a  = 8'($urandom);
            b  = 8'($urandom);
            at = 8'($urandom & $urandom & $urandom);
            bt = 8'($urandom & $urandom);
            st = ($urandom_range(0, 7) == 0);
            run_op(a, b, at, bt, st, lat);
            checks++;
            if (lat != 10 || product !== 16'(a) * 16'(b)) begin
                errors++;
                $display("FAIL random_product: got P=%0d lat=%0d want %0d lat 10", product, lat, 16'(a) * 16'(b));
            end
            checks++;
            if (product_t !== model_t(a, b, at, bt, st) || done_t !== st) begin
                errors++;
                $display("FAIL random_taint: got Pt=%h dt=%b want %h %b", product_t, done_t, model_t(a, b, at, bt, st), st);
            end
        end
    endtask

    task automatic test_restart_ignored();
        int ndone = 0;
        int first = -1;
        @(negedge clk);
        mplier = 8'd200; mcand = 8'd100; mplier_t = 8'h0; mcand_t = 8'h01; start_t = 1'b0; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        for (int e = 1; e <= 16; e++) begin
            @(posedge clk);
            #1;
            if (done === 1'b1) begin ndone++; if (first < 0) first = e; end
            start = (e == 5);
        end
        start = 1'b0;
        $display("restart op: dones=%0d first=%0d P=%0d Pt=%h", ndone, first, product, product_t);
        checks++;
        if (ndone != 1 || first != 10) begin
            errors++;
            $display("FAIL restart_ignored: got dones=%0d at %0d want 1 at 10", ndone, first);
        end
        checks++;
        if (product !== 16'd20000 || product_t !== model_t(8'd200, 8'd100, 8'h0, 8'h01, 1'b0)) begin
            errors++;
            $display("FAIL restart_result: got P=%0d Pt=%h want 20000 %h", product, product_t,
                     model_t(8'd200, 8'd100, 8'h0, 8'h01, 1'b0));
        end
    endtask

    task automatic test_reset_mid();
        int seen = 0;
        int lat;
        @(negedge clk);
        mplier = 8'd77; mcand = 8'd33; mplier_t = 8'h0; mcand_t = 8'h0; start_t = 1'b1; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (5) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        checks++;
        if ({busy, done, done_t, product, product_t} !== 35'h0) begin
            errors++;
            $display("FAIL reset_mid_outputs: got busy=%b done=%b dt=%b P=%h Pt=%h want all 0",
                     busy, done, done_t, product, product_t);
        end
        repeat (3) begin
            @(posedge clk);
            #1 if (done === 1'b1) seen++;
        end
        @(posedge clk);
        #1 rst_n = 1'b1;
        for (int e = 0; e < 12; e++) begin
            @(posedge clk);
            #1 if (done === 1'b1) seen++;
        end
        checks++;
        if (seen != 0) begin errors++; $display("FAIL reset_mid_no_done: got %0d dones want 0", seen); end
        @(posedge clk);
        #1 rst_n = 1'b0;
        #1 rst_n = 1'b1;
        // start presented so the first edge after release samples it
        run_op(8'd77, 8'd33, 8'h0, 8'h0, 1'b0, lat);
        checks++;
        if (lat != 10 || product !== 16'd2541 || product_t !== 16'h0 || done_t !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_next_op: got P=%0d Pt=%h dt=%b lat=%0d want 2541 0 0 10",
                     product, product_t, done_t, lat);
        end
    endtask

    task automatic test_back_to_back();
        int lat1, lat2;
        logic [15:0] p1;
        run_op(8'd13, 8'd11, 8'h0, 8'h0, 1'b0, lat1);
        p1 = product;
        run_op(8'd250, 8'd9, 8'h10, 8'h0, 1'b0, lat2);
        checks++;
        if (lat1 != 10 || lat2 != 10 || p1 !== 16'd143 || product !== 16'd2250) begin
            errors++;
            $display("FAIL back_to_back: got lat %0d/%0d P %0d/%0d want 10/10 143/2250", lat1, lat2, p1, product);
        end
        checks++;
        if (product_t !== model_t(8'd250, 8'd9, 8'h10, 8'h0, 1'b0)) begin
            errors++;
            $display("FAIL back_to_back_taint: got %h want %h", product_t, model_t(8'd250, 8'd9, 8'h10, 8'h0, 1'b0));
        end
    endtask

`ifdef MULT_TAINT_KILL_EN
    task automatic test_kill();
        int lat = 0;
        @(negedge clk);
        mplier = 8'hFF; mcand = 8'hFF; mplier_t = 8'h0; mcand_t = 8'hFF; start_t = 1'b1; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        while (done !== 1'b1 && lat < 30) begin
            @(posedge clk);
            #1 lat++;
            taint_kill = (lat == 8);
        end
        taint_kill = 1'b0;
        $display("kill op: P=%h Pt=%h dt=%b lat=%0d", product, product_t, done_t, lat);
        checks++;
        if (lat != 10 || product !== 16'hFE01 || product_t !== 16'h0 || done_t !== 1'b0) begin
            errors++;
            $display("FAIL kill: got P=%h Pt=%h dt=%b lat=%0d want FE01 0 0 10", product, product_t, done_t, lat);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_arith();
        test_taint();
        test_random();
        test_restart_ignored();
        test_reset_mid();
        test_back_to_back();
`ifdef MULT_TAINT_KILL_EN
        test_kill();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/multiplier_ct_taint.md
MULTIPLIER_CT_TAINT -- requirements
Module: multiplier_ct_taint

Interface
REQ-001 SHALL have parameter NUM_BITS, default 8, operand width (>=2).
REQ-002 SHALL have port clk  input  1  sole clock, all state on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port start  input  1  operation request, sampled in IDLE only.
REQ-005 SHALL have port multiplier  input  NUM_BITS  unsigned operand A.
REQ-006 SHALL have port multiplicand  input  NUM_BITS  unsigned operand B.
REQ-007 SHALL have port start_t  input  1  taint of start.
REQ-008 SHALL have port multiplier_t  input  NUM_BITS  per-bit taint of A.
REQ-009 SHALL have port multiplicand_t  input  NUM_BITS  per-bit taint of B.
REQ-010 SHALL have port busy  output  1  high in LOAD and CALC.
REQ-011 SHALL have port done  output  1  one-cycle pulse, result valid.
REQ-012 SHALL have port product  output  2*NUM_BITS  unsigned A*B.
REQ-013 SHALL have port product_t  output  2*NUM_BITS  per-bit taint of product.
REQ-014 SHALL have port done_t  output  1  taint of done/busy timing.

Function
REQ-015 SHALL implement FSM IDLE -> LOAD -> CALC -> DONE -> IDLE.
REQ-016 IDLE: start=1 at rising edge -> LOAD; start=0 stays IDLE; start ignored in all other states.
REQ-017 LOAD: capture A, B, their taints and start_t; clear accumulator and accumulator taint; iteration counter=0.
REQ-018 CALC: exactly NUM_BITS cycles, iteration i adds (A[i] ? B<<i : 0) to accumulator; no early exit for any operand value (constant time).
REQ-019 DONE: done=1 for exactly one cycle, product/product_t updated to final accumulator values on entry; then IDLE.
REQ-020 Latency SHALL be NUM_BITS+2 cycles from edge sampling start to edge where done rises, independent of operand values and taints.
REQ-021 product, product_t, done_t SHALL hold until the next DONE entry.
REQ-022 Per iteration, addend taint SHALL be: all ones in bits [i, i+NUM_BITS-1] if A_t[i]; else B_t<<i if A[i]; else 0.
REQ-023 Carry smear: if addend taint lowest set bit is k, accumulator taint bits k..2*NUM_BITS-1 SHALL become 1; existing taint bits never clear during CALC.
REQ-024 Captured start_t=1 SHALL force product_t all ones and done_t=1 at DONE; otherwise done_t=0.
REQ-025 Accumulator arithmetic SHALL be 2*NUM_BITS wide, no overflow possible.

Reset
REQ-026 rst_n low SHALL immediately force IDLE, busy=0, done=0, done_t=0, product=0, product_t=0, counter=0.
REQ-027 rst_n asserted mid-CALC SHALL abort the operation with no done pulse; next start after release runs a full operation.
REQ-028 After rst_n deassertion, start in the first clock edge SHALL be accepted.

Configuration
REQ-029 Macro MULT_TAINT_KILL_EN SHALL, when defined, add port taint_kill  input  1.
REQ-030 With MULT_TAINT_KILL_EN: taint_kill=1 at an edge clears accumulator taint, captured operand/start taints, product_t and done_t that cycle, overriding REQ-022..024 updates; arithmetic and timing unaffected.
REQ-031 Without MULT_TAINT_KILL_EN: no taint_kill port; taint cleared only by reset or LOAD.

Verification (NUM_BITS=8)
REQ-032 A=15, B=15, no taint, start one cycle -> done exactly 10 cycles later, product=225, product_t=0, done_t=0.
REQ-033 A=0, B=12 -> done still at cycle 10, product=0; 92*75 -> 6900; 42*78 -> 3276.
REQ-034 A=1, B=2, B_t=8'h80 -> product=2, product_t=16'hFF80; A_t=8'h04, B_t=0 -> product_t=16'hFFFC.
REQ-035 start_t=1, A=3, B=5 -> product=15, product_t=16'hFFFF, done_t=1.
REQ-036 start re-pulsed during CALC -> ignored, single done at cycle 10; rst_n low at CALC cycle 4 -> no done, outputs 0, subsequent op correct.
REQ-037 With MULT_TAINT_KILL_EN: B_t=8'hFF, A=8'hFF, taint_kill at last CALC cycle -> product=16'hFE01, product_t=0.
